mips_fetch_stage: RTL and testbench
===================================

// Module: mips_fetch_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register. Drives the decoder's instr_o/pcp4_o.
//   Owns the PC and a one-outstanding-request instruction-memory port with variable latency.
//   A 1-entry skid buffer absorbs responses that arrive during an ID stall.
//   Applies branch/jump redirects and flushes resolved in ID; a macro selects delay-slot semantics.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC of the first fetch after reset
//   NOP_INSTR  32'h0000_0000   instruction injected on flush (sll $0,$0,0)
// PORTS
//   clk_i           in   1   single clock, rising edge
//   reset_i         in   1   asynchronous, active-high reset
//   imem_req_o      out  1   fetch request, one cycle per request
//   imem_addr_o     out  32  fetch address, word aligned
//   imem_rvalid_i   in   1   response valid, >=1 cycle after req
//   imem_rdata_i    in   32  response instruction
//   stall_i         in   1   ID stall (load-use hazard); hold IF/ID
//   redirect_i      in   1   branch taken / jump / jr resolved in ID
//   redirect_pc_i   in   32  target of redirect (bits [1:0] ignored, forced 0)
//   valid_o         out  1   IF/ID holds a live instruction
//   instr_o         out  32  IF/ID instruction to decoder
//   pcp4_o          out  32  IF/ID PC+4 (link value, branch base)
// BEHAVIOUR
//   Reset values: pc=RESET_PC; state=S_IDLE; skid empty; imem_req_o=0; imem_addr_o=0; valid_o=0; instr_o=NOP_INSTR; pcp4_o=0.
//   FSM S_IDLE / S_WAIT / S_DROP. At most one request outstanding.
//   S_IDLE: skid empty -> imem_req_o=1, imem_addr_o=pc, go S_WAIT. Skid full -> no request.
//     rvalid ignored here, including stale responses after a mid-operation reset.
//   S_WAIT, rvalid && !redirect: response accepted; pc+=4 (mod 2^32, wraps); go S_IDLE.
//   S_WAIT, redirect && !rvalid: pc=redirect_pc_i; go S_DROP.
//   S_WAIT, redirect && rvalid: response discarded; pc=target; go S_IDLE.
//   S_DROP: next rvalid discarded, go S_IDLE. A further redirect in S_DROP updates pc and stays in S_DROP.
//   IF/ID update, priority order:
//     redirect -> valid_o=0, instr_o=NOP_INSTR, skid cleared (overrides stall_i);
//     stall_i  -> hold; an accepted response goes to the skid (never lost);
//     else     -> load skid if full (accepted response then refills skid),
//                 else load accepted response, else valid_o=0/instr_o=NOP.
//   pcp4_o = fetch address of the loaded instruction + 4.
//   Latency: request to IF/ID = memory latency + 1 edge. Zero-wait memory sustains 1 instr / 2 cycles.
//   Redirect to first target request: next cycle in S_IDLE. In S_DROP, after the stale response.
// CONFIGURATION
//   MIPS_FETCH_DELAY_SLOT_EN defined: MIPS branch delay slot.
//     The first instruction younger than the redirecting one is kept. This is the skid entry if full,
//     else the in-flight response, else the next sequential fetch.
//     Target is latched and applied to pc when the slot instruction is accepted; no S_DROP entry.
//     IF/ID is not flushed if the slot is already in the skid; the slot is delivered normally.
//   Undefined: no delay slot. All younger instructions flushed as above.
// STRUCTURE
//   defs.v: `FS_IDLE/`FS_WAIT/`FS_DROP 2-bit state codes, `NOP_INSTR default.
//   Sub-module mips_fetch_skid: 1-entry {instr,pcp4} buffer with push/pop/clear/full.
// TESTING
//   1. Reset, 1-cycle memory, no stall -> addrs 0,4,8; valid_o instrs in order; pcp4_o 4,8,12.
//   2. 3-cycle latency -> imem_req_o only after each rvalid; never two outstanding.
//   3. stall_i 3 cycles while a response arrives -> IF/ID held, skid full, no new req; release -> skid word delivered next, no loss or duplication.
//   4. redirect_i (target 0x100) while in S_WAIT -> S_DROP; stale rdata 0xDEAD not delivered; next addr 0x100.
//   5. redirect && rvalid same cycle, stall_i=1 -> flush wins, valid_o=0, next addr = target.
//   6. MIPS_FETCH_DELAY_SLOT_EN: redirect at PC 8 to 0x40 -> instr at 0xC delivered, then 0x40, 0x44.
//   7. reset_i asserted mid-S_WAIT -> outputs to reset values immediately; stale rvalid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
//   fetch_state_e   : fetch FSM state codes (S_IDLE / S_WAIT / S_DROP)
//   NOP_INSTR_DEF   : default bubble instruction (sll $0,$0,0)
//   INSTR_STEP      : byte distance between sequential instructions
//   word_align()    : forces the two low address bits to zero
package mips_fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DROP = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] INSTR_STEP    = 32'h0000_0004;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
//   imem_req    : fetch request, one cycle per request (fetch -> memory)
//   imem_addr   : word-aligned fetch address            (fetch -> memory)
//   imem_rvalid : response valid, >=1 cycle after req    (memory -> fetch)
//   imem_rdata  : response instruction                   (memory -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
interface mips_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_rvalid, input imem_rdata);
    modport slave  (input  imem_req, input imem_addr,
                    output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/mips_fetch_stage_skid.sv
// mips_fetch_skid: one-entry {instr, pcp4} buffer that catches a fetch
// response arriving while the decoder is stalled.
//   clk_i, reset_i      : clock, asynchronous active-high reset
//   push                : store push_instr/push_pcp4 (wins over pop, so a
//                         simultaneous pop+push refills the entry)
//   pop                 : entry consumed by IF/ID
//   clear               : drop the entry (flush), highest priority
//   full, instr, pcp4   : entry state and contents
module mips_fetch_skid #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pcp4,
    output logic        full,
    output logic [31:0] instr,
    output logic [31:0] pcp4
);

    logic        full_r;
    logic [31:0] instr_r;
    logic [31:0] pcp4_r;

    // Entry register: clear beats push, push beats pop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_r  <= 1'b0;
            instr_r <= NOP_INSTR;
            pcp4_r  <= 32'h0000_0000;
        end else if (clear) begin
            full_r  <= 1'b0;
        end else if (push) begin
            full_r  <= 1'b1;
            instr_r <= push_instr;
            pcp4_r  <= push_pcp4;
        end else if (pop) begin
            full_r  <= 1'b0;
        end else begin
            full_r  <= full_r;
        end
    end

    assign full  = full_r;
    assign instr = instr_r;
    assign pcp4  = pcp4_r;

endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: MIPS instruction fetch + IF/ID pipeline register.
// Owns the PC, issues at most one outstanding instruction-memory request,
// buffers one response in a skid while ID stalls, and applies redirects.
// Ports:
//   clk_i, reset_i          : clock, asynchronous active-high reset
//   imem (master modport)   : request/response instruction-memory port
//   stall_i                 : ID stall, hold IF/ID
//   redirect_i/redirect_pc_i: taken branch / jump target resolved in ID
//   valid_o, instr_o, pcp4_o: IF/ID register towards the decoder
// Build option: define MIPS_FETCH_DELAY_SLOT_EN for branch-delay-slot
// semantics; default build flushes every instruction younger than the
// redirecting one.
module mips_fetch_stage
    import mips_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    mips_fetch_stage_if.master         imem,
    input  logic                       stall_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                pcp4_o
);

    fetch_state_e state_r, state_s;
    logic [31:0]  pc_r, pc_s;
    logic         run_r;          // low for the first cycle after reset so no request escapes reset
    logic         req_s;
    logic         accept_s;
    logic         flush_s;
    logic [31:0]  target_s;
    logic [31:0]  fetch_pcp4_s;
    logic         valid_r, valid_s;
    logic [31:0]  instr_r, instr_s;
    logic [31:0]  pcp4_r, pcp4_s;
    logic         skid_push_s, skid_pop_s, skid_clear_s, skid_full_s;
    logic [31:0]  skid_instr_s, skid_pcp4_s;
`ifdef MIPS_FETCH_DELAY_SLOT_EN
    logic         pend_r, pend_s;         // redirect waiting for its delay-slot fetch
    logic [31:0]  pend_pc_r, pend_pc_s;
`endif

    assign target_s     = word_align(redirect_pc_i);
    // While waiting, pc_r is always the address of the in-flight request.
    assign fetch_pcp4_s = pc_r + INSTR_STEP;

    // The request is decoded from registered state so a zero-wait memory can
    // answer in the following cycle (one instruction every two cycles).
    assign imem.imem_req  = req_s;
    assign imem.imem_addr = req_s ? pc_r : 32'h0000_0000;

    // Fetch FSM: next state, next PC and request/accept strobes.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        req_s    = 1'b0;
        accept_s = 1'b0;
`ifdef MIPS_FETCH_DELAY_SLOT_EN
        pend_s    = pend_r;
        pend_pc_s = pend_pc_r;
`endif
        case (state_r)
            S_IDLE: begin
`ifdef MIPS_FETCH_DELAY_SLOT_EN
                // Slot already sitting in the skid: retarget now; otherwise the
                // next sequential fetch is the slot and the target waits for it.
                if (redirect_i && skid_full_s) begin
                    pc_s = target_s;
                end else if (redirect_i) begin
                    pend_s    = 1'b1;
                    pend_pc_s = target_s;
                end else begin
                    pend_s = pend_r;
                end
                if (run_r && !skid_full_s) begin
                    req_s   = 1'b1;
                    state_s = S_WAIT;
                end else begin
                    state_s = S_IDLE;
                end
`else
                // A redirect suppresses this cycle's request so the target is
                // fetched in the very next cycle without a stale response.
                if (redirect_i) begin
                    pc_s = target_s;
                end else if (run_r && !skid_full_s) begin
                    req_s   = 1'b1;
                    state_s = S_WAIT;
                end else begin
                    state_s = S_IDLE;
                end
`endif
            end
            S_WAIT: begin
`ifdef MIPS_FETCH_DELAY_SLOT_EN
                if (imem.imem_rvalid) begin
                    accept_s = 1'b1;
                    state_s  = S_IDLE;
                    pend_s   = 1'b0;
                    if (redirect_i) begin
                        pc_s = target_s;
                    end else if (pend_r) begin
                        pc_s = pend_pc_r;
                    end else begin
                        pc_s = fetch_pcp4_s;
                    end
                end else if (redirect_i) begin
                    pend_s    = 1'b1;
                    pend_pc_s = target_s;
                end else begin
                    state_s = S_WAIT;
                end
`else
                if (redirect_i) begin
                    pc_s    = target_s;
                    state_s = imem.imem_rvalid ? S_IDLE : S_DROP;
                end else if (imem.imem_rvalid) begin
                    accept_s = 1'b1;
                    pc_s     = fetch_pcp4_s;
                    state_s  = S_IDLE;
                end else begin
                    state_s = S_WAIT;
                end
`endif
            end
            S_DROP: begin
                if (redirect_i) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
                if (imem.imem_rvalid) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DROP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Fetch state, PC and start-up flag registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            run_r   <= 1'b1;
        end
    end

`ifdef MIPS_FETCH_DELAY_SLOT_EN
    // Pending delay-slot redirect target.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_r    <= 1'b0;
            pend_pc_r <= 32'h0000_0000;
        end else begin
            pend_r    <= pend_s;
            pend_pc_r <= pend_pc_s;
        end
    end
`endif

    // IF/ID next value: flush, then stall, then skid, then fresh response.
    always_comb begin
        valid_s      = valid_r;
        instr_s      = instr_r;
        pcp4_s       = pcp4_r;
        skid_push_s  = 1'b0;
        skid_pop_s   = 1'b0;
        skid_clear_s = 1'b0;
`ifdef MIPS_FETCH_DELAY_SLOT_EN
        flush_s = 1'b0;
`else
        flush_s = redirect_i;
`endif
        if (flush_s) begin
            valid_s      = 1'b0;
            instr_s      = NOP_INSTR;
            skid_clear_s = 1'b1;
        end else if (stall_i) begin
            skid_push_s = accept_s;
        end else if (skid_full_s) begin
            valid_s     = 1'b1;
            instr_s     = skid_instr_s;
            pcp4_s      = skid_pcp4_s;
            skid_pop_s  = 1'b1;
            skid_push_s = accept_s;
        end else if (accept_s) begin
            valid_s = 1'b1;
            instr_s = imem.imem_rdata;
            pcp4_s  = fetch_pcp4_s;
        end else begin
            valid_s = 1'b0;
            instr_s = NOP_INSTR;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            pcp4_r  <= 32'h0000_0000;
        end else begin
            valid_r <= valid_s;
            instr_r <= instr_s;
            pcp4_r  <= pcp4_s;
        end
    end

    assign valid_o = valid_r;
    assign instr_o = instr_r;
    assign pcp4_o  = pcp4_r;

    mips_fetch_skid #(.NOP_INSTR(NOP_INSTR)) u_skid (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push       (skid_push_s),
        .pop        (skid_pop_s),
        .clear      (skid_clear_s),
        .push_instr (imem.imem_rdata),
        .push_pcp4  (fetch_pcp4_s),
        .full       (skid_full_s),
        .instr      (skid_instr_s),
        .pcp4       (skid_pcp4_s)
    );

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed testbench for mips_fetch_stage with a variable-latency memory model.
module tb_mips_fetch_stage;

    typedef logic [31:0] wq_t[$];

    logic        clk;
    logic        reset_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pcp4_o;

    mips_fetch_stage_if bus();

    mips_fetch_stage dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .imem          (bus),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pcp4_o        (pcp4_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          mem_lat;
    int          mem_cnt;
    logic        mem_busy;
    logic [31:0] mem_addr;
    logic        stale_en;
    logic [31:0] stale_word;
    logic        s_stall;
    logic        s_redir;
    logic [31:0] s_tgt;
    logic        prev_stall;
    wq_t         req_q;
    wq_t         del_i_q;
    wq_t         del_p_q;
    int          req_c[$];
    int          del_c[$];
    wq_t         e_req;
    wq_t         e_del;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2400_0000 | a;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compares request addresses and delivered instructions against address lists.
    task automatic check_run(input string tag, input wq_t ereq, input wq_t edel);
        check_val({tag, "_req_cnt"}, 32'(req_q.size()), 32'(ereq.size()));
        for (int i = 0; i < ereq.size() && i < req_q.size(); i++)
            check_val($sformatf("%s_req[%0d]", tag, i), req_q[i], ereq[i]);
        check_val({tag, "_del_cnt"}, 32'(del_i_q.size()), 32'(edel.size()));
        for (int i = 0; i < edel.size() && i < del_i_q.size(); i++) begin
            check_val($sformatf("%s_instr[%0d]", tag, i), del_i_q[i], mem_word(edel[i]));
            check_val($sformatf("%s_pcp4[%0d]", tag, i), del_p_q[i], edel[i] + 32'h4);
        end
    endtask

    task automatic clear_logs();
        req_q.delete(); del_i_q.delete(); del_p_q.delete();
        req_c.delete(); del_c.delete();
    endtask

    // One clock cycle: memory response, stimulus, then sampling of outputs.
    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = stale_en ? stale_word : mem_word(mem_addr);
                stale_en        = 1'b0;
                mem_busy        = 1'b0;
            end
        end
        stall_i       = s_stall;
        redirect_i    = s_redir;
        redirect_pc_i = s_tgt;
        #1;
        if (valid_o && !prev_stall) begin
            del_i_q.push_back(instr_o);
            del_p_q.push_back(pcp4_o);
            del_c.push_back(cyc);
        end
        prev_stall = stall_i;
        if (bus.imem_req) begin
            check_val("one_outstanding", {31'b0, mem_busy}, 32'h0000_0000);
            req_q.push_back(bus.imem_addr);
            req_c.push_back(cyc);
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = bus.imem_addr;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_valid"}, {31'b0, valid_o}, 32'h0000_0000);
        check_val({tag, "_instr"}, instr_o, 32'h0000_0000);
        check_val({tag, "_pcp4"}, pcp4_o, 32'h0000_0000);
        check_val({tag, "_req"}, {31'b0, bus.imem_req}, 32'h0000_0000);
        check_val({tag, "_addr"}, bus.imem_addr, 32'h0000_0000);
    endtask

    // Reset for two edges; the next tick() is the first cycle that may request.
    task automatic do_reset(input int lat);
        reset_i = 1'b1;
        s_stall = 1'b0; s_redir = 1'b0; s_tgt = 32'h0000_0000;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0000_0000;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0000_0000;
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0000_0000;
        stale_en = 1'b0; stale_word = 32'h0000_0000;
        mem_lat = lat; prev_stall = 1'b0; cyc = 0;
        clear_logs();
        @(posedge clk); #1;
        check_reset_vals("reset");
        @(posedge clk); #1;
        reset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // 1: zero-wait memory, sequential stream at one instruction per two cycles.
        do_reset(1);
        repeat (8) tick();
        e_req = '{32'h0, 32'h4, 32'h8, 32'hC};
        e_del = '{32'h0, 32'h4, 32'h8};
        check_run("t1", e_req, e_del);
        if (del_c.size() >= 3) begin
            check_val("t1_rate01", 32'(del_c[1] - del_c[0]), 32'd2);
            check_val("t1_rate12", 32'(del_c[2] - del_c[1]), 32'd2);
        end

        // 2: 3-cycle latency, request only after each response.
        do_reset(3);
        repeat (13) tick();
        e_req = '{32'h0, 32'h4, 32'h8, 32'hC};
        e_del = '{32'h0, 32'h4, 32'h8};
        check_run("t2", e_req, e_del);
        if (req_c.size() >= 3) begin
            check_val("t2_gap01", 32'(req_c[1] - req_c[0]), 32'd4);
            check_val("t2_gap12", 32'(req_c[2] - req_c[1]), 32'd4);
        end

        // 3: three-cycle stall while a response arrives; skid keeps it.
        do_reset(1);
        repeat (2) tick();
        s_stall = 1'b1;
        repeat (3) tick();
        check_val("t3_no_req", {31'b0, bus.imem_req}, 32'h0000_0000);
        check_val("t3_hold_valid", {31'b0, valid_o}, 32'h0000_0001);
        check_val("t3_hold_instr", instr_o, 32'h2400_0000);
        s_stall = 1'b0;
        repeat (7) tick();
        e_req = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        e_del = '{32'h0, 32'h4, 32'h8, 32'hC};
        check_run("t3", e_req, e_del);

`ifndef MIPS_FETCH_DELAY_SLOT_EN
        // 4: redirect while waiting; stale 0xDEAD dropped; target low bits ignored.
        do_reset(3);
        tick();
        s_redir = 1'b1; s_tgt = 32'h0000_0102;
        stale_en = 1'b1; stale_word = 32'h0000_DEAD;
        tick();
        s_redir = 1'b0;
        tick();
        check_val("t4_flush_valid", {31'b0, valid_o}, 32'h0000_0000);
        repeat (7) tick();
        e_req = '{32'h0, 32'h100, 32'h104};
        e_del = '{32'h100};
        check_run("t4", e_req, e_del);

        // 5: redirect and response together under stall; flush wins.
        do_reset(1);
        repeat (3) tick();
        s_redir = 1'b1; s_stall = 1'b1; s_tgt = 32'h0000_0200;
        tick();
        s_redir = 1'b0; s_stall = 1'b0;
        tick();
        check_val("t5_flush_valid", {31'b0, valid_o}, 32'h0000_0000);
        check_val("t5_flush_instr", instr_o, 32'h0000_0000);
        check_val("t5_target_addr", bus.imem_addr, 32'h0000_0200);
        repeat (2) tick();
        e_req = '{32'h0, 32'h4, 32'h200, 32'h204};
        e_del = '{32'h0, 32'h200};
        check_run("t5", e_req, e_del);
`endif

        // 6: redirect while IF/ID holds the instruction at PC 8, target 0x40.
        do_reset(1);
        repeat (6) tick();
        s_redir = 1'b1; s_tgt = 32'h0000_0040;
        tick();
        check_val("t6_branch_pcp4", pcp4_o, 32'h0000_000C);
        s_redir = 1'b0;
        repeat (6) tick();
`ifdef MIPS_FETCH_DELAY_SLOT_EN
        e_req = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h44, 32'h48};
        e_del = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h44};
`else
        e_req = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44, 32'h48};
        e_del = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44};
`endif
        check_run("t6", e_req, e_del);

        // 7: reset in the middle of a wait; stale response ignored afterwards.
        do_reset(3);
        repeat (5) tick();
        check_val("t7_pre_valid", {31'b0, valid_o}, 32'h0000_0001);
        stale_en = 1'b1; stale_word = 32'hBAD0_0000;
        tick();
        reset_i = 1'b1;
        #1;
        check_reset_vals("t7_async");
        tick();
        reset_i = 1'b0;
        clear_logs();
        repeat (5) tick();
        e_req = '{32'h0, 32'h4};
        e_del = '{32'h0};
        check_run("t7", e_req, e_del);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
